maze_port_arbiter: RTL and testbench

- Shares the single maze memory port (row, col, maze_oe, maze_we, maze_in) between NUM_REQ solver engines.
- Lets several wall-follower walkers, or a walker plus a debug/scan agent, run against one maze RAM.
- Round-robin arbitration; one access issued per clock, fully pipelined.
- Returns read data to the requester that issued the read.

---
 rtl/maze_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_maze_port_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/maze_port_arbiter.sv
// Round-robin share of one maze RAM port among NUM_REQ solver engines; reads return one cycle after issue.
// Optional owner lock for atomic read-check-mark sequences: define MAZE_PORT_ARBITER_LOCK_EN.
module maze_port_arbiter #(
  parameter int MAZE_WIDTH = 6,
  parameter int NUM_REQ    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*MAZE_WIDTH-1:0] req_row,
  input  logic [NUM_REQ*MAZE_WIDTH-1:0] req_col,
`ifdef MAZE_PORT_ARBITER_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock,
`endif
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic                          rd_data,
  output logic [MAZE_WIDTH-1:0]         row,
  output logic [MAZE_WIDTH-1:0]         col,
  output logic                          maze_oe,
  output logic                          maze_we,
  input  logic                          maze_in
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDXW-1:0]       ptr;
  logic [IDXW-1:0]       iss_idx;
  logic                  tag_vld;
  logic [IDXW-1:0]       tag_idx;
  logic [NUM_REQ-1:0]    cand;
  logic                  win_any;
  logic [IDXW-1:0]       win_idx;
  logic [NUM_REQ-1:0]    win_oh;
  logic [MAZE_WIDTH-1:0] row_arr [NUM_REQ];
  logic [MAZE_WIDTH-1:0] col_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      row_arr[i] = req_row[i*MAZE_WIDTH +: MAZE_WIDTH];
      col_arr[i] = req_col[i*MAZE_WIDTH +: MAZE_WIDTH];
    end
  end

`ifdef MAZE_PORT_ARBITER_LOCK_EN
  localparam logic [0:0] ST_OPEN   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]      lock_state;
  logic [IDXW-1:0] lock_owner;

  // While locked only the owner is visible to the search, so others are masked.
  always_comb begin
    cand = req;
    if (lock_state == ST_LOCKED) begin
      cand = '0;
      cand[lock_owner] = req[lock_owner];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_state <= ST_OPEN;
      lock_owner <= '0;
    end else if (lock_state == ST_OPEN) begin
      if (win_any && req_lock[win_idx]) begin
        lock_state <= ST_LOCKED;
        lock_owner <= win_idx;
      end
    end else begin
      if (!req[lock_owner] || (win_any && !req_lock[win_idx])) begin
        lock_state <= ST_OPEN;
      end
    end
  end

  logic ptr_load;
  assign ptr_load = win_any && (lock_state == ST_OPEN);
`else
  assign cand = req;

  logic ptr_load;
  assign ptr_load = win_any;
`endif

  // First candidate strictly after the pointer, wrapping, so the last winner has lowest priority.
  always_comb begin
    logic [IDXW-1:0] idx;
    win_any = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDXW'((int'(ptr) + k) % NUM_REQ);
      if (!win_any && cand[idx]) begin
        win_any = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_comb begin
    win_oh          = '0;
    win_oh[win_idx] = win_any;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt     <= '0;
      maze_oe <= 1'b0;
      maze_we <= 1'b0;
      row     <= '0;
      col     <= '0;
      iss_idx <= '0;
      ptr     <= IDXW'(NUM_REQ - 1);
    end else begin
      gnt     <= win_oh;
      maze_oe <= win_any & ~req_we[win_idx];
      maze_we <= win_any &  req_we[win_idx];
      if (win_any) begin
        row     <= row_arr[win_idx];
        col     <= col_arr[win_idx];
        iss_idx <= win_idx;
      end
      if (ptr_load) begin
        ptr <= win_idx;
      end
    end
  end

  // Read tag: remembers who owns the read currently at the memory, one cycle behind issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= 1'b0;
      tag_idx <= '0;
    end else begin
      tag_vld <= maze_oe;
      tag_idx <= iss_idx;
    end
  end

  always_comb begin
    rd_valid = '0;
    if (tag_vld) begin
      rd_valid[tag_idx] = 1'b1;
    end
  end

  assign rd_data = maze_in;

endmodule

// File: tb/tb_maze_port_arbiter.sv
// Scoreboard bench for maze_port_arbiter: stimulus pushes expected issues/returns, a monitor pops and compares.
module tb_maze_port_arbiter;

  localparam int MW = 6;
  localparam int NR = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req;
  logic [NR-1:0]    req_we;
  logic [NR*MW-1:0] req_row;
  logic [NR*MW-1:0] req_col;
  logic [NR-1:0]    req_lock;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    rd_valid;
  logic             rd_data;
  logic [MW-1:0]    row;
  logic [MW-1:0]    col;
  logic             maze_oe;
  logic             maze_we;
  logic             maze_in = 1'b0;

  maze_port_arbiter #(.MAZE_WIDTH(MW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
    .req_row(req_row), .req_col(req_col),
`ifdef MAZE_PORT_ARBITER_LOCK_EN
    .req_lock(req_lock),
`endif
    .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .row(row), .col(col), .maze_oe(maze_oe), .maze_we(maze_we),
    .maze_in(maze_in)
  );

  always #5 clk = ~clk;

  // Maze RAM model: writes mark a cell, two cells are preset as walls.
  bit marked [64][64];
  function automatic bit preset(input logic [MW-1:0] r, input logic [MW-1:0] c);
    return (r == 6'd5 && c == 6'd7) || (r == 6'd2 && c == 6'd2);
  endfunction
  always @(posedge clk) begin
    if (maze_we) marked[row][col] <= 1'b1;
    if (maze_oe) maze_in <= marked[row][col] | preset(row, col);
  end

  typedef struct {
    logic [NR-1:0] g;
    logic          oe;
    logic          we;
    logic [MW-1:0] r;
    logic [MW-1:0] c;
  } iss_t;
  typedef struct {
    logic [NR-1:0] v;
    logic          d;
  } rd_t;

  iss_t exp_iss[$];
  rd_t  exp_rd[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic push_iss(input logic [NR-1:0] g, input logic we, input int r, input int c);
    iss_t e;
    e.g = g; e.oe = ~we; e.we = we; e.r = MW'(r); e.c = MW'(c);
    exp_iss.push_back(e);
  endtask

  task automatic push_rd(input logic [NR-1:0] v, input logic d);
    rd_t e;
    e.v = v; e.d = d;
    exp_rd.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (gnt != '0 || maze_oe || maze_we) begin
        if (exp_iss.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_issue: got gnt=%b oe=%b we=%b row=%0d col=%0d expected none at %0t",
                   gnt, maze_oe, maze_we, row, col, $time);
        end else begin
          iss_t e;
          e = exp_iss.pop_front();
          chk("gnt", 32'(gnt), 32'(e.g));
          chk("maze_oe", 32'(maze_oe), 32'(e.oe));
          chk("maze_we", 32'(maze_we), 32'(e.we));
          chk("row", 32'(row), 32'(e.r));
          chk("col", 32'(col), 32'(e.c));
        end
      end
      if (rd_valid != '0) begin
        if (exp_rd.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_rd_valid: got %b expected none at %0t", rd_valid, $time);
        end else begin
          rd_t e;
          e = exp_rd.pop_front();
          chk("rd_valid", 32'(rd_valid), 32'(e.v));
          chk("rd_data", 32'(rd_data), 32'(e.d));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input int r, input int c);
    req_row[i*MW +: MW] = MW'(r);
    req_col[i*MW +: MW] = MW'(c);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_we = '0; req_row = '0; req_col = '0; req_lock = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_oe_we", 32'({maze_oe, maze_we}), 0);
    chk("rst_row_col", 32'({row, col}), 0);
    rst_n = 1'b1;
    cyc();

    // Single read; requester 0 has priority out of reset.
    req = 2'b01; req_we = 2'b00; set_addr(0, 5, 7);
    push_iss(2'b01, 1'b0, 5, 7); push_rd(2'b01, 1'b1);
    cyc();
    req = 2'b00;
    repeat (3) cyc();

    // Write by 0, then read of the same cell by 1 in the next arbitration.
    req = 2'b01; req_we = 2'b01; set_addr(0, 3, 3);
    push_iss(2'b01, 1'b1, 3, 3);
    cyc();
    req = 2'b10; req_we = 2'b00; set_addr(1, 3, 3);
    push_iss(2'b10, 1'b0, 3, 3); push_rd(2'b10, 1'b1);
    cyc();
    req = 2'b00;
    repeat (3) cyc();

    // Contention: both reading continuously for four cycles.
    req = 2'b11; req_we = 2'b00; set_addr(0, 1, 1); set_addr(1, 2, 2);
    for (int k = 0; k < 2; k++) begin
      push_iss(2'b01, 1'b0, 1, 1); push_rd(2'b01, 1'b0);
      push_iss(2'b10, 1'b0, 2, 2); push_rd(2'b10, 1'b1);
    end
    repeat (4) cyc();
    req = 2'b00;
    repeat (3) cyc();

    // Withdrawal: requester 1 asks for one cycle while 0 wins, then drops.
    req = 2'b11; req_we = 2'b00; set_addr(0, 10, 10); set_addr(1, 20, 20);
    push_iss(2'b01, 1'b0, 10, 10); push_rd(2'b01, 1'b0);
    cyc();
    req = 2'b00;
    repeat (4) cyc();

    // Reset during the grant cycle of a read: the read return must vanish.
    req = 2'b01; req_we = 2'b00; set_addr(0, 5, 7);
    push_iss(2'b01, 1'b0, 5, 7);
    cyc();
    req = 2'b00;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_oe", 32'(maze_oe), 0);
    chk("midrst_gnt", 32'(gnt), 0);
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    req = 2'b11; set_addr(0, 5, 7); set_addr(1, 2, 2);
    push_iss(2'b01, 1'b0, 5, 7); push_rd(2'b01, 1'b1);
    push_iss(2'b10, 1'b0, 2, 2); push_rd(2'b10, 1'b1);
    cyc();
    req = 2'b10;
    cyc();
    req = 2'b00;
    repeat (5) cyc();

    chk("iss_left", 32'(exp_iss.size()), 0);
    chk("rd_left", 32'(exp_rd.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
